// File: rtl/terminal_tx_queue.sv
// Host-side transmit queue feeding a mesh router terminal: show-ahead FIFO with destination check.
// Optional rejected-push counter enabled by defining TERMINAL_TX_DROP_CNT_EN.
module terminal_tx_queue #(
    parameter int          ROW        = 4,
    parameter int          COLUMS     = 4,
    parameter int          pckg_sz    = 41,
    parameter int          fifo_depth = 4,
    parameter logic [7:0]  broadcast  = 8'hFF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [3:0]                        wr_row,
    input  logic [3:0]                        wr_col,
    input  logic                              wr_mode,
    input  logic [pckg_sz-10:0]               wr_payload,
    output logic                              full,
    output logic [$clog2(fifo_depth+1)-1:0]   count,
    output logic                              bad_dst,
`ifdef TERMINAL_TX_DROP_CNT_EN
    output logic [7:0]                        drop_cnt,
`endif
    output logic [pckg_sz-1:0]                data_out_i_in,
    output logic                              pndng_i_in,
    input  logic                              popin
);

    localparam int PW = $clog2(fifo_depth);
    localparam int CW = $clog2(fifo_depth+1);

    logic [pckg_sz-1:0] r_mem [fifo_depth];
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic               r_full;
    logic               r_pndng;
    logic               r_bad_dst;

    logic [7:0]         w_id;
    logic               w_legal;
    logic               w_push;
    logic               w_pop;
    logic [CW-1:0]      w_cnt_nxt;
    logic [pckg_sz-1:0] w_pkt;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(fifo_depth-1)) ? '0 : p + PW'(1);
    endfunction

    assign w_id    = {wr_row, wr_col};
    assign w_legal = (w_id == broadcast) ||
                     ((32'(wr_row) < ROW) && (32'(wr_col) < COLUMS));
    assign w_pkt   = {wr_row, wr_col, wr_mode, wr_payload};

    // Full is the registered flag, so a push in the full state is refused even if a pop frees a slot.
    assign w_push  = wr_en && !r_full && w_legal;
    assign w_pop   = popin && r_pndng;

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_push && !w_pop)
            w_cnt_nxt = r_count + CW'(1);
        else if (w_pop && !w_push)
            w_cnt_nxt = r_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < fifo_depth; i++)
                r_mem[i] <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_pndng   <= 1'b0;
            r_bad_dst <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_pkt;
                r_wr_ptr        <= f_inc(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= f_inc(r_rd_ptr);
            if (wr_en && !w_legal)
                r_bad_dst <= 1'b1;
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CW'(fifo_depth));
            r_pndng <= (w_cnt_nxt != '0);
        end
    end

`ifdef TERMINAL_TX_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic       w_drop;

    assign w_drop = wr_en && (r_full || !w_legal);

    always_ff @(posedge clk) begin
        if (reset)
            r_drop_cnt <= '0;
        else if (w_drop && (r_drop_cnt != 8'hFF))
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign full          = r_full;
    assign count         = r_count;
    assign bad_dst       = r_bad_dst;
    assign pndng_i_in    = r_pndng;
    assign data_out_i_in = r_mem[r_rd_ptr];

endmodule
